// File: rtl/cpu_pkg.sv
// Shared sysbus definitions: address map, status-word layout and the status packing helper.
package cpu_pkg;

  localparam int WORD_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = WORD_W - OP_W;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  localparam logic [ADDR_W-1:0] OUT_ADDR  = 5'd31;
  localparam logic [ADDR_W-1:0] SW_ADDR   = 5'd30;
  localparam logic [ADDR_W-1:0] STAT_ADDR = 5'd29;

  localparam int STAT_OVF   = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_OUT  = 2'd1,
    DEC_STAT = 2'd2
  } dec_e;

  function automatic logic [WORD_W-1:0] pack_status(input logic ovf, input logic full,
                                                    input logic empty, input logic [CNT_W-1:0] cnt);
    logic [WORD_W-1:0] w;
    w              = '0;
    w[STAT_OVF]    = ovf;
    w[STAT_FULL]   = full;
    w[STAT_EMPTY]  = empty;
    w[CNT_W-1:0]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/output_port_if.sv
// Control strobes and sink handshake of the output port; master is the CPU/sink side.
interface output_port_if;
  import cpu_pkg::*;

  logic              load_MAR;
  logic              MDR_bus;
  logic              R_NW;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave  (input  load_MAR, MDR_bus, R_NW, out_ready, output out_data, out_valid);
  modport master (output load_MAR, MDR_bus, R_NW, out_ready, input  out_data, out_valid);
endinterface

// File: rtl/sync_fifo.sv
// Register-based FIFO with zero-latency head read; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == FULL_CNT);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, cleared on reset so the head reads zero afterwards
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/output_port.sv
// Memory-mapped byte output: stores to OUT_ADDR feed a FIFO drained by a valid/ready sink,
// loads from STAT_ADDR return occupancy plus a sticky overflow flag.
module output_port
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  // sysbus is a direct port so the tri-state resolves on the net every bus agent shares
  inout  wire [WORD_W-1:0]  sysbus,
  output_port_if.slave      bus
);

  logic [ADDR_W-1:0] mar_r;
  logic              ovf_r;
  dec_e              dec_s;
  logic              store_s;
  logic              stat_rd_s;
  logic              pop_s;
  logic              lost_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  count_s;
  logic [WORD_W-1:0] dout_s;
  logic [WORD_W-1:0] status_s;

  // Decode the latched address into the register this port owns, if any
  always_comb begin
    dec_s = DEC_NONE;
    case (mar_r)
      OUT_ADDR:  dec_s = DEC_OUT;
      STAT_ADDR: dec_s = DEC_STAT;
      SW_ADDR:   dec_s = DEC_NONE;
      default:   dec_s = DEC_NONE;
    endcase
  end

  // Qualify the bus strobes with the decoded target
  always_comb begin
    store_s   = 1'b0;
    stat_rd_s = 1'b0;
    case (dec_s)
      DEC_OUT:  store_s   = !bus.R_NW;
      DEC_STAT: stat_rd_s = bus.MDR_bus;
      default: begin
        store_s   = 1'b0;
        stat_rd_s = 1'b0;
      end
    endcase
  end

  assign pop_s  = bus.out_ready && !fifo_empty_s;
  // A store into a full FIFO is only lost when no pop frees a slot on the same edge
  assign lost_s = store_s && fifo_full_s && !pop_s;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (store_s),
    .pop   (pop_s),
    .din   (sysbus),
    .dout  (dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_s)
  );

  // Address register loaded from the low bits of sysbus
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mar_r <= '0;
    end else if (bus.load_MAR) begin
      mar_r <= sysbus[ADDR_W-1:0];
    end
  end

  // Sticky overflow; a fresh loss wins over the clear from a coincident status read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (lost_s) begin
      ovf_r <= 1'b1;
    end else if (stat_rd_s) begin
      ovf_r <= 1'b0;
    end
  end

  assign status_s      = pack_status(ovf_r, fifo_full_s, fifo_empty_s, count_s);
  assign sysbus        = stat_rd_s ? status_s : {WORD_W{1'bz}};
  assign bus.out_valid = !fifo_empty_s;
  assign bus.out_data  = dout_s;

endmodule
